// File: rtl/nios_system_sysid_ext.sv
// System-ID register bank: ID/timestamp constants, tear-free 64-bit uptime,
// seconds counter, scratch register and sticky W1C status, on Avalon-MM.
module nios_system_sysid_ext #(
    parameter logic [31:0] SYS_ID        = 32'h00C0FFEE,
    parameter logic [31:0] TIMESTAMP     = 32'd1480634848,
    parameter int unsigned CLK_FREQ_HZ   = 50000000,
    parameter logic [31:0] SCRATCH_RESET = 32'h00000000,
    // Uptime value loaded at reset; zero in normal use, nonzero only to
    // reach carry/wrap points without running for billions of cycles.
    parameter logic [63:0] UPTIME_RESET  = 64'h0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        readdatavalid
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned UP_W   = 64;
    localparam int unsigned PRE_W  = (CLK_FREQ_HZ > 2) ? $clog2(CLK_FREQ_HZ) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_FREQ_HZ - 1);

    localparam logic [2:0] A_ID      = 3'd0;
    localparam logic [2:0] A_TS      = 3'd1;
    localparam logic [2:0] A_UP_LO   = 3'd2;
    localparam logic [2:0] A_UP_HI   = 3'd3;
    localparam logic [2:0] A_SCRATCH = 3'd4;
    localparam logic [2:0] A_STATUS  = 3'd5;
    localparam logic [2:0] A_SECONDS = 3'd6;

    logic [UP_W-1:0]   r_uptime;
    logic [DATA_W-1:0] r_hi_shadow;
    logic [PRE_W-1:0]  r_prescaler;
    logic [DATA_W-1:0] r_seconds;
    logic [DATA_W-1:0] r_scratch;
    logic [1:0]        r_status;
    logic [DATA_W-1:0] r_readdata;
    logic              r_readdatavalid;

    logic [DATA_W-1:0] w_rd_data;
    logic              w_wr_ro;
    logic              w_collision;
    logic [1:0]        w_status_clr;
    logic [1:0]        w_status_set;

    // Free-running uptime counter, wraps naturally at 2^64
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_uptime <= UPTIME_RESET;
        end else begin
            r_uptime <= r_uptime + UP_W'(1);
        end
    end

    // Prescaler divides the clock down to one tick per second
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_prescaler <= '0;
            r_seconds   <= '0;
        end else if (r_prescaler == PRE_MAX) begin
            r_prescaler <= '0;
            r_seconds   <= r_seconds + DATA_W'(1);
        end else begin
            r_prescaler <= r_prescaler + PRE_W'(1);
        end
    end

    // Write decode for sticky status events and W1C clears
    always_comb begin
        w_wr_ro      = 1'b0;
        w_collision  = read && write;
        w_status_clr = 2'b00;
        if (write) begin
            case (address)
                A_ID, A_TS, A_UP_LO, A_UP_HI, A_SECONDS: w_wr_ro = 1'b1;
                A_STATUS: w_status_clr = writedata[1:0] & {2{byteenable[0]}};
                default: w_wr_ro = 1'b0;
            endcase
        end
        w_status_set = {w_collision, w_wr_ro};
    end

    // Sticky status: a same-cycle set beats a W1C clear
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_status <= 2'b00;
        end else begin
            r_status <= (r_status & ~w_status_clr) | w_status_set;
        end
    end

    // Scratch register with per-byte write enables
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_scratch <= SCRATCH_RESET;
        end else if (write && (address == A_SCRATCH)) begin
            for (int b = 0; b < 4; b++) begin
                if (byteenable[b]) begin
                    r_scratch[8*b +: 8] <= writedata[8*b +: 8];
                end
            end
        end
    end

    // Read mux samples pre-write state so a colliding read sees old data
    always_comb begin
        w_rd_data = '0;
        case (address)
            A_ID:      w_rd_data = SYS_ID;
            A_TS:      w_rd_data = TIMESTAMP;
            A_UP_LO:   w_rd_data = r_uptime[31:0];
            A_UP_HI:   w_rd_data = r_hi_shadow;
            A_SCRATCH: w_rd_data = r_scratch;
            A_STATUS:  w_rd_data = {30'd0, r_status};
            A_SECONDS: w_rd_data = r_seconds;
            default:   w_rd_data = '0;
        endcase
    end

    // Low-word read latches the high word so software sees a consistent pair
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_hi_shadow <= '0;
        end else if (read && (address == A_UP_LO)) begin
            r_hi_shadow <= r_uptime[63:32];
        end
    end

    // Fixed one-cycle read latency; data holds between reads
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata      <= '0;
            r_readdatavalid <= 1'b0;
        end else begin
            r_readdatavalid <= read;
            if (read) begin
                r_readdata <= w_rd_data;
            end
        end
    end

    assign readdata      = r_readdata;
    assign readdatavalid = r_readdatavalid;

endmodule

// File: tb/tb_nios_system_sysid_ext.sv
// Directed bench for nios_system_sysid_ext: vector table plus corner sequences.
module tb_nios_system_sysid_ext;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = 3'd0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = 32'd0;
    logic [3:0]  byteenable = 4'd0;
    logic [31:0] rd_a, rd_b;
    logic        rv_a, rv_b;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    // Main DUT: fast seconds tick, uptime preset just below the 32-bit carry
    nios_system_sysid_ext #(
        .SYS_ID(32'h00C0FFEE), .TIMESTAMP(32'd1480634848), .CLK_FREQ_HZ(4),
        .SCRATCH_RESET(32'h0BADF00D), .UPTIME_RESET(64'h00000000_FFFFFFF0)
    ) dut (
        .clock(clock), .reset_n(reset_n), .address(address), .read(read),
        .write(write), .writedata(writedata), .byteenable(byteenable),
        .readdata(rd_a), .readdatavalid(rv_a)
    );

    // Second DUT: uptime preset just below the 64-bit wrap
    nios_system_sysid_ext #(
        .UPTIME_RESET(64'hFFFFFFFF_FFFFFFFE)
    ) dut_w (
        .clock(clock), .reset_n(reset_n), .address(address), .read(read),
        .write(write), .writedata(writedata), .byteenable(byteenable),
        .readdata(rd_b), .readdatavalid(rv_b)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        exp_v;
        logic [31:0] exp_d;
    } vec_t;

    localparam int NV = 29;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Apply one bus cycle at the falling edge, then sample just after the rising edge
    task automatic cyc(input logic rd, input logic wr, input logic [2:0] a,
                       input logic [31:0] wd, input logic [3:0] be);
        @(negedge clock);
        read = rd; write = wr; address = a; writedata = wd; byteenable = be;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 3'd0, 32'd0, 4'd0);
    endtask

    task automatic rd_chk(input string name, input logic [2:0] a, input logic [31:0] exp);
        cyc(1'b1, 1'b0, a, 32'd0, 4'd0);
        check({name, "_valid"}, {31'd0, rv_a}, 32'd1);
        check(name, rd_a, exp);
    endtask

    task automatic rd_chk_w(input string name, input logic [2:0] a, input logic [31:0] exp);
        cyc(1'b1, 1'b0, a, 32'd0, 4'd0);
        check({name, "_valid"}, {31'd0, rv_b}, 32'd1);
        check(name, rd_b, exp);
    endtask

    // Reset with outputs checked while held; release away from any edge
    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        read = 1'b0; write = 1'b0; address = 3'd0; writedata = 32'd0; byteenable = 4'd0;
        @(posedge clock);
        #1;
        check("rst_readdata", rd_a, 32'd0);
        check("rst_valid", {31'd0, rv_a}, 32'd0);
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 3'd4, 32'h0,        4'h0, 1'b1, 32'h0BADF00D};
        vecs[1]  = '{1'b1, 1'b0, 3'd0, 32'h0,        4'h0, 1'b1, 32'h00C0FFEE};
        vecs[2]  = '{1'b1, 1'b0, 3'd1, 32'h0,        4'h0, 1'b1, 32'd1480634848};
        vecs[3]  = '{1'b0, 1'b0, 3'd1, 32'h0,        4'h0, 1'b0, 32'd1480634848};
        vecs[4]  = '{1'b0, 1'b1, 3'd4, 32'hA5A5A5A5, 4'hF, 1'b0, 32'd1480634848};
        vecs[5]  = '{1'b0, 1'b1, 3'd4, 32'h00003C00, 4'h2, 1'b0, 32'd1480634848};
        vecs[6]  = '{1'b1, 1'b0, 3'd4, 32'h0,        4'h0, 1'b1, 32'hA5A53CA5};
        vecs[7]  = '{1'b1, 1'b0, 3'd5, 32'h0,        4'h0, 1'b1, 32'h0};
        vecs[8]  = '{1'b0, 1'b1, 3'd0, 32'hFFFFFFFF, 4'hF, 1'b0, 32'h0};
        vecs[9]  = '{1'b1, 1'b0, 3'd5, 32'h0,        4'h0, 1'b1, 32'h1};
        vecs[10] = '{1'b1, 1'b0, 3'd0, 32'h0,        4'h0, 1'b1, 32'h00C0FFEE};
        vecs[11] = '{1'b0, 1'b1, 3'd5, 32'h1,        4'h0, 1'b0, 32'h00C0FFEE};
        vecs[12] = '{1'b1, 1'b0, 3'd5, 32'h0,        4'h0, 1'b1, 32'h1};
        vecs[13] = '{1'b0, 1'b1, 3'd5, 32'h1,        4'h1, 1'b0, 32'h1};
        vecs[14] = '{1'b1, 1'b0, 3'd5, 32'h0,        4'h0, 1'b1, 32'h0};
        vecs[15] = '{1'b0, 1'b1, 3'd7, 32'hFFFFFFFF, 4'hF, 1'b0, 32'h0};
        vecs[16] = '{1'b1, 1'b0, 3'd5, 32'h0,        4'h0, 1'b1, 32'h0};
        vecs[17] = '{1'b1, 1'b0, 3'd7, 32'h0,        4'h0, 1'b1, 32'h0};
        vecs[18] = '{1'b0, 1'b1, 3'd1, 32'h0,        4'hF, 1'b0, 32'h0};
        vecs[19] = '{1'b1, 1'b0, 3'd5, 32'h0,        4'h0, 1'b1, 32'h1};
        vecs[20] = '{1'b1, 1'b1, 3'd4, 32'h12345678, 4'hF, 1'b1, 32'hA5A53CA5};
        vecs[21] = '{1'b1, 1'b0, 3'd4, 32'h0,        4'h0, 1'b1, 32'h12345678};
        vecs[22] = '{1'b1, 1'b0, 3'd5, 32'h0,        4'h0, 1'b1, 32'h3};
        vecs[23] = '{1'b1, 1'b1, 3'd5, 32'h2,        4'h1, 1'b1, 32'h3};
        vecs[24] = '{1'b1, 1'b0, 3'd5, 32'h0,        4'h0, 1'b1, 32'h3};
        vecs[25] = '{1'b0, 1'b1, 3'd5, 32'h3,        4'h1, 1'b0, 32'h3};
        vecs[26] = '{1'b1, 1'b0, 3'd5, 32'h0,        4'h0, 1'b1, 32'h0};
        vecs[27] = '{1'b0, 1'b1, 3'd6, 32'h0,        4'hF, 1'b0, 32'h0};
        vecs[28] = '{1'b1, 1'b0, 3'd5, 32'h0,        4'h0, 1'b1, 32'h1};

        // Register map, byte lanes, W1C, sticky errors, read/write collision
        do_reset();
        for (int i = 0; i < NV; i++) begin
            cyc(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be);
            check($sformatf("vec%0d_valid", i), {31'd0, rv_a}, {31'd0, vecs[i].exp_v});
            check($sformatf("vec%0d_data", i), rd_a, vecs[i].exp_d);
        end

        // Seconds tick with a 4-cycle prescaler: boundaries at 8 and 12 cycles
        do_reset(); idle(7);  rd_chk("sec_after7",  3'd6, 32'd1);
        do_reset(); idle(8);  rd_chk("sec_after8",  3'd6, 32'd2);
        do_reset(); idle(10); rd_chk("sec_after10", 3'd6, 32'd2);
        do_reset(); idle(11); rd_chk("sec_after11", 3'd6, 32'd2);
        do_reset(); idle(12); rd_chk("sec_after12", 3'd6, 32'd3);

        // Uptime low/high pair across the 32-bit carry
        do_reset();
        rd_chk("hi_shadow_rst", 3'd3, 32'h0);
        idle(14);
        rd_chk("up_lo_pre_carry", 3'd2, 32'hFFFFFFFF);
        rd_chk("up_hi_pre_carry", 3'd3, 32'h00000000);
        rd_chk("up_lo_post_carry", 3'd2, 32'h00000001);
        rd_chk("up_hi_post_carry", 3'd3, 32'h00000001);

        // Uptime wrap from all-ones to zero
        do_reset();
        idle(1);
        rd_chk_w("wrap_lo_ones", 3'd2, 32'hFFFFFFFF);
        rd_chk_w("wrap_hi_ones", 3'd3, 32'hFFFFFFFF);
        rd_chk_w("wrap_lo_after", 3'd2, 32'h00000001);
        rd_chk_w("wrap_hi_after", 3'd3, 32'h00000000);

        // Reset asserted mid-access clears outputs immediately
        do_reset();
        cyc(1'b1, 1'b0, 3'd0, 32'd0, 4'd0);
        check("midrd_valid", {31'd0, rv_a}, 32'd1);
        check("midrd_data", rd_a, 32'h00C0FFEE);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_data", rd_a, 32'd0);
        check("async_rst_valid", {31'd0, rv_a}, 32'd0);
        @(negedge clock);
        read = 1'b0;
        @(posedge clock);
        #3;
        reset_n = 1'b1;
        cyc(1'b0, 1'b0, 3'd0, 32'd0, 4'd0);
        check("post_rst_valid", {31'd0, rv_a}, 32'd0);
        check("post_rst_data", rd_a, 32'd0);

        // Read held during reset produces no pulse after release
        @(negedge clock);
        reset_n = 1'b0;
        read = 1'b1;
        address = 3'd0;
        @(posedge clock);
        #1;
        check("rd_in_rst_valid", {31'd0, rv_a}, 32'd0);
        @(negedge clock);
        read = 1'b0;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        check("rd_after_rst_valid", {31'd0, rv_a}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nios_system_sysid_ext.md
Name: nios_system_sysid_ext

Overview:
- Parametrised Avalon-MM slave that extends the system-ID peripheral into a small register bank.
- Provides ID and build timestamp constants, a 64-bit tear-free uptime counter, a seconds counter, a scratch register and a sticky status/error register.
- Sits on the Nios II data master's interconnect. Software uses it for hardware/software version checks, bus sanity tests and coarse timekeeping.

Parameters:
- SYS_ID, 32'h00C0FFEE, value returned at word 0.
- TIMESTAMP, 32'd1480634848, build timestamp returned at word 1.
- CLK_FREQ_HZ, 50000000, clock cycles per second for the seconds prescaler; legal range ≥ 2.
- SCRATCH_RESET, 32'h00000000, reset value of the scratch register.

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  3  word address.
- read  in  1  read strobe.
- write  in  1  write strobe.
- writedata  in  32  write data.
- byteenable  in  4  byte lanes for writes.
- readdata  out  32  registered read data.
- readdatavalid  out  1  one-cycle pulse qualifying readdata.

Behaviour:
- Reset is asynchronous on reset_n low. Reset values:
  - readdata = 0, readdatavalid = 0
  - uptime = 0, seconds = 0, prescaler = 0
  - scratch = SCRATCH_RESET, status = 0, hi_shadow = 0
- No waitrequest. Every strobe is accepted in the cycle it is asserted.
- Read latency is fixed at 1. A read at cycle t drives readdata and readdatavalid=1 at t+1.
- readdatavalid is low in every cycle that does not follow an accepted read. readdata holds its last value when readdatavalid is low.
- Register map:
  - 0 ID (RO) = SYS_ID
  - 1 TS (RO) = TIMESTAMP
  - 2 UPTIME_LO (RO) = uptime[31:0] at cycle t. The same edge loads hi_shadow with uptime[63:32] from cycle t.
  - 3 UPTIME_HI (RO) = hi_shadow. Reading it does not update hi_shadow.
  - 4 SCRATCH (RW), byte-lane writes per byteenable.
  - 5 STATUS (RW1C): bit0 = ro_write_err, bit1 = rw_collision, bits[31:2] read 0.
  - 6 SECONDS (RO) = seconds.
  - 7 reserved: reads 0, writes ignored.
- Uptime counter:
  - 64-bit, increments every cycle out of reset, wraps from all-ones to 0.
- Seconds counter:
  - Prescaler counts 0..CLK_FREQ_HZ-1.
  - When the prescaler is at CLK_FREQ_HZ-1, it returns to 0 and seconds increments (32-bit, wraps).
- Writes:
  - Write to address 0, 1, 2, 3 or 6: no data effect; sets ro_write_err.
  - Write to address 5: each status bit clears where writedata has 1 and its byteenable lane is set.
  - If a W1C clear and a new set of the same bit occur in the same cycle, set wins.
- Read and write in the same cycle:
  - The write is performed and rw_collision is set.
  - The read is still serviced; its data is sampled before the write takes effect, so scratch returns the old value.
- Reset mid-read: a read accepted in the cycle before reset asserts produces no readdatavalid after reset.
- Addresses wrap within 3 bits; there are no out-of-range accesses.

Test Plan:
- Reset, then read addresses 0 and 1 → readdata 32'h00C0FFEE and 32'd1480634848; readdatavalid exactly one cycle each, 1 cycle after read.
- Write SCRATCH 32'hA5A5A5A5 with byteenable 4'b1111, then byteenable 4'b0010 with data 32'h00003C00, read back → 32'hA5A53CA5.
- Force uptime to 64'h00000000_FFFFFFFF, read UPTIME_LO at that cycle, then read UPTIME_HI → 32'hFFFFFFFF then 32'h00000000 (no tearing across the carry); free-run wrap from all-ones gives 0.
- With CLK_FREQ_HZ=4, run 10 cycles after reset, read SECONDS → 2; prescaler period is exactly 4 cycles.
- Write address 0, read STATUS → 32'h1 and ID unchanged. Write STATUS 32'h1 → reads 0. Same-cycle write-clear plus new RO write → bit0 stays 1.
- Read SCRATCH and write 32'h12345678 to it in the same cycle → returned data is the old value, a later read gives 32'h12345678, STATUS bit1 = 1. Assert reset_n low mid-access → all outputs 0 asynchronously.
